pa_clic_int_dlvr: RTL and testbench
===================================

# pa_clic_int_dlvr

Delivery stage between the CLIC priority arbitration kernel and the core interrupt interface. Registers the winning request (id, priority, hv), qualifies it against the interrupt threshold, and presents it to the core with a valid/ack handshake. On ack it issues a one-cycle pending-clear for the taken id, then holds off re-arbitration until the clear has propagated.

## Interface
- PRIO_WIDTH, 6, priority/level width; matches the arbitration kernel.
- ID_WIDTH, 12, interrupt id width.
- HOLD_CYC, 2, cycles with no delivery after an ack; legal range 1..15.

- clic_clk  in  1  block clock
- cpurst_b  in  1  asynchronous active-low reset
- arb_req  in  1  kernel winner valid
- arb_id  in  ID_WIDTH  kernel winner id
- arb_prio  in  PRIO_WIDTH  kernel winner priority
- arb_hv  in  1  kernel winner hardware-vectored flag
- int_thresh  in  PRIO_WIDTH  current threshold; winner qualifies only if arb_prio > int_thresh
- core_int_ack  in  1  core takes presented interrupt
- clic_int_vld  out  1  interrupt presented to core
- clic_int_id  out  ID_WIDTH  presented id
- clic_int_prio  out  PRIO_WIDTH  presented priority
- clic_int_hv  out  1  presented hv flag
- pend_clr_vld  out  1  one-cycle pulse: clear pending for pend_clr_id
- pend_clr_id  out  ID_WIDTH  id to clear

## Operation
- qual = arb_req && (arb_prio > int_thresh), unsigned compare.
- FSM states IDLE, PRESENT, HOLD. Reset -> IDLE.
- IDLE: clic_int_vld=0. If qual: capture arb_id/arb_prio/arb_hv into output regs, next state PRESENT.
- PRESENT: clic_int_vld=1; outputs stable unless replaced (see Configuration).
  - core_int_ack=1: next state HOLD; next cycle pend_clr_vld=1, pend_clr_id=held id. Ack wins over all other events in the same cycle.
  - no ack, qual=0 (request withdrawn or threshold raised): next state IDLE (withdraw).
  - otherwise remain PRESENT.
- HOLD: clic_int_vld=0; down-counter loaded with HOLD_CYC-1 on entry; exits to IDLE when counter is 0. arb_* ignored.
- core_int_ack outside PRESENT: ignored, no pend_clr pulse.
- clic_int_id/prio/hv keep their last captured value while vld=0. Consumers qualify on vld.

## Timing
- Reset values: clic_int_vld=0, clic_int_id=0, clic_int_prio=0, clic_int_hv=0, pend_clr_vld=0, pend_clr_id=0, counter=0.
- All outputs registered. Latency arb_req qualifying -> clic_int_vld high: 1 cycle.
- Ack in cycle N: vld low in N+1; pend_clr_vld high exactly in N+1; earliest next vld high in N+1+HOLD_CYC.
- Withdraw in cycle N: vld low in N+1; no pend_clr pulse.
- Reset asserted mid-operation: immediate return to reset values; in-flight pend_clr pulse lost.

## Configuration
- CLIC_INT_PREEMPT_EN defined: in PRESENT with no ack, if qual && arb_prio > clic_int_prio && arb_id != clic_int_id, replace id/prio/hv next cycle; vld stays 1 with no gap.
- Undefined: PRESENT outputs locked until ack or withdraw; a higher-priority winner waits for the current one to be acked or withdrawn.

## Structure
- Shared package pa_clic_pkg: FSM state encoding (IDLE=2'b00, PRESENT=2'b01, HOLD=2'b10) and default PRIO_WIDTH/ID_WIDTH constants.
- Single module, no sub-module. Hold counter 4 bits, inline.

## Test plan
- Reset: hold cpurst_b=0 with arb_req=1 -> all outputs 0; release, arb_req=1, prio=5, thresh=3, id=0x012 -> vld=1 next cycle with id 0x012, prio 5.
- Threshold: prio=3, thresh=3 -> vld stays 0; thresh drops to 2 -> vld=1 one cycle later.
- Ack: PRESENT with id 0x020, ack in cycle N -> pend_clr_vld=1 with id 0x020 only in N+1; vld=0 in N+1 and N+2 (HOLD_CYC=2); vld=1 in N+3 if still qualified.
- Withdraw: PRESENT, arb_req drops -> vld=0 next cycle, pend_clr_vld never asserts.
- Preempt with CLIC_INT_PREEMPT_EN: presenting id 0x004, prio 4; winner id 0x009, prio 7 -> output id 0x009, prio 7 next cycle, vld continuously 1. Without the macro: output stays 0x004.
- Simultaneous: ack plus higher-priority winner in the same cycle -> ack wins; pend_clr_id = old id; new winner presented after HOLD.

Source files
------------

// File: rtl/pa_clic_pkg.sv
// Shared CLIC definitions: delivery FSM state encoding and default field widths.
package pa_clic_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_PRESENT = 2'b01;
    localparam logic [1:0] ST_HOLD    = 2'b10;

    localparam int PA_CLIC_PRIO_WIDTH = 6;
    localparam int PA_CLIC_ID_WIDTH   = 12;

endpackage

// File: rtl/pa_clic_int_dlvr.sv
// CLIC interrupt delivery: registers the arbitration winner, presents it to the core with
// valid/ack, pulses a pending-clear on ack and blocks delivery for HOLD_CYC cycles.
// Optional in-place preemption of a presented interrupt: define CLIC_INT_PREEMPT_EN.
module pa_clic_int_dlvr
    import pa_clic_pkg::*;
#(
    parameter int PRIO_WIDTH = PA_CLIC_PRIO_WIDTH,
    parameter int ID_WIDTH   = PA_CLIC_ID_WIDTH,
    parameter int HOLD_CYC   = 2
) (
    input  logic                  clic_clk,
    input  logic                  cpurst_b,
    input  logic                  arb_req,
    input  logic [ID_WIDTH-1:0]   arb_id,
    input  logic [PRIO_WIDTH-1:0] arb_prio,
    input  logic                  arb_hv,
    input  logic [PRIO_WIDTH-1:0] int_thresh,
    input  logic                  core_int_ack,
    output logic                  clic_int_vld,
    output logic [ID_WIDTH-1:0]   clic_int_id,
    output logic [PRIO_WIDTH-1:0] clic_int_prio,
    output logic                  clic_int_hv,
    output logic                  pend_clr_vld,
    output logic [ID_WIDTH-1:0]   pend_clr_id
);

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYC - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [3:0]            r_hold_cnt;
    logic                  r_vld;
    logic [ID_WIDTH-1:0]   r_id;
    logic [PRIO_WIDTH-1:0] r_prio;
    logic                  r_hv;
    logic                  r_clr_vld;
    logic [ID_WIDTH-1:0]   r_clr_id;

    logic w_qual;
    logic w_hold_done;
    logic w_take;
    logic w_capture;
    logic w_preempt;

    assign w_qual      = arb_req && (arb_prio > int_thresh);
    assign w_take      = (r_state == ST_PRESENT) && core_int_ack;
    // The last hold cycle doubles as the idle decision so vld is low for exactly HOLD_CYC cycles.
    assign w_hold_done = (r_state == ST_HOLD) && (r_hold_cnt == 4'd0);
    assign w_capture   = w_qual && ((r_state == ST_IDLE) || w_hold_done);

`ifdef CLIC_INT_PREEMPT_EN
    assign w_preempt = (r_state == ST_PRESENT) && !core_int_ack && w_qual &&
                       (arb_prio > r_prio) && (arb_id != r_id);
`else
    assign w_preempt = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_qual) w_state_next = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (core_int_ack)  w_state_next = ST_HOLD;
                else if (!w_qual)  w_state_next = ST_IDLE;
            end
            ST_HOLD: begin
                if (r_hold_cnt == 4'd0) w_state_next = w_qual ? ST_PRESENT : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clic_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= 4'd0;
            r_vld      <= 1'b0;
            r_id       <= '0;
            r_prio     <= '0;
            r_hv       <= 1'b0;
            r_clr_vld  <= 1'b0;
            r_clr_id   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_vld     <= (w_state_next == ST_PRESENT);
            r_clr_vld <= w_take;
            if (w_take) begin
                r_clr_id <= r_id;
            end
            if (w_capture || w_preempt) begin
                r_id   <= arb_id;
                r_prio <= arb_prio;
                r_hv   <= arb_hv;
            end
            if (w_take) begin
                r_hold_cnt <= HOLD_LOAD;
            end else if ((r_state == ST_HOLD) && (r_hold_cnt != 4'd0)) begin
                r_hold_cnt <= r_hold_cnt - 4'd1;
            end
        end
    end

    assign clic_int_vld  = r_vld;
    assign clic_int_id   = r_id;
    assign clic_int_prio = r_prio;
    assign clic_int_hv   = r_hv;
    assign pend_clr_vld  = r_clr_vld;
    assign pend_clr_id   = r_clr_id;

endmodule

// File: tb/tb_pa_clic_int_dlvr.sv
// Directed, table-driven bench for pa_clic_int_dlvr (HOLD_CYC=2); preemption expectations
// follow CLIC_INT_PREEMPT_EN.
module tb_pa_clic_int_dlvr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arb_req;
    logic [11:0] arb_id;
    logic [5:0]  arb_prio;
    logic        arb_hv;
    logic [5:0]  int_thresh;
    logic        core_int_ack;
    logic        clic_int_vld;
    logic [11:0] clic_int_id;
    logic [5:0]  clic_int_prio;
    logic        clic_int_hv;
    logic        pend_clr_vld;
    logic [11:0] pend_clr_id;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pa_clic_int_dlvr #(
        .PRIO_WIDTH (6),
        .ID_WIDTH   (12),
        .HOLD_CYC   (2)
    ) dut (
        .clic_clk      (clk),
        .cpurst_b      (rst_n),
        .arb_req       (arb_req),
        .arb_id        (arb_id),
        .arb_prio      (arb_prio),
        .arb_hv        (arb_hv),
        .int_thresh    (int_thresh),
        .core_int_ack  (core_int_ack),
        .clic_int_vld  (clic_int_vld),
        .clic_int_id   (clic_int_id),
        .clic_int_prio (clic_int_prio),
        .clic_int_hv   (clic_int_hv),
        .pend_clr_vld  (pend_clr_vld),
        .pend_clr_id   (pend_clr_id)
    );

    typedef struct {
        logic        rst_n;
        logic        req;
        logic [11:0] id;
        logic [5:0]  prio;
        logic        hv;
        logic [5:0]  thr;
        logic        ack;
        logic        e_vld;
        logic [11:0] e_id;
        logic [5:0]  e_prio;
        logic        e_hv;
        logic        e_clr;
        logic [11:0] e_clr_id;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic r, logic q, logic [11:0] id, logic [5:0] p, logic h,
                                logic [5:0] t, logic a, logic ev, logic [11:0] eid,
                                logic [5:0] ep, logic eh, logic ec, logic [11:0] ecid);
        vec_t v;
        v.rst_n = r; v.req = q; v.id = id; v.prio = p; v.hv = h; v.thr = t; v.ack = a;
        v.e_vld = ev; v.e_id = eid; v.e_prio = ep; v.e_hv = eh; v.e_clr = ec; v.e_clr_id = ecid;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic q, input logic [11:0] id, input logic [5:0] p,
                         input logic h, input logic [5:0] t, input logic a);
        rst_n = r; arb_req = q; arb_id = id; arb_prio = p; arb_hv = h; int_thresh = t; core_int_ack = a;
    endtask

    task automatic check_all(input int idx, input logic ev, input logic [11:0] eid, input logic [5:0] ep,
                             input logic eh, input logic ec, input logic [11:0] ecid);
        chk("vld", idx, 32'(clic_int_vld), 32'(ev));
        chk("id", idx, 32'(clic_int_id), 32'(eid));
        chk("prio", idx, 32'(clic_int_prio), 32'(ep));
        chk("hv", idx, 32'(clic_int_hv), 32'(eh));
        chk("clr_vld", idx, 32'(pend_clr_vld), 32'(ec));
        chk("clr_id", idx, 32'(pend_clr_id), 32'(ecid));
        $display("step %0d: vld=%0b id=%03h prio=%0d hv=%0b clr=%0b clr_id=%03h", idx,
                 clic_int_vld, clic_int_id, clic_int_prio, clic_int_hv, pend_clr_vld, pend_clr_id);
    endtask

    logic [11:0] pre_id;
    logic [5:0]  pre_prio;
    logic        pre_hv;

    initial begin
        //              rst req id      prio hv thr ack | vld id     prio hv clr clr_id
        vecs[0]  = mk(0, 1, 12'h012, 5, 1, 3, 0,   0, 12'h000, 0, 0, 0, 12'h000);
        vecs[1]  = mk(0, 1, 12'h012, 5, 1, 3, 0,   0, 12'h000, 0, 0, 0, 12'h000);
        vecs[2]  = mk(1, 1, 12'h012, 5, 1, 3, 0,   1, 12'h012, 5, 1, 0, 12'h000);
        vecs[3]  = mk(1, 1, 12'h012, 5, 1, 3, 1,   0, 12'h012, 5, 1, 1, 12'h012);
        vecs[4]  = mk(1, 1, 12'h012, 5, 1, 3, 0,   0, 12'h012, 5, 1, 0, 12'h012);
        vecs[5]  = mk(1, 0, 12'h012, 5, 1, 3, 0,   0, 12'h012, 5, 1, 0, 12'h012);
        vecs[6]  = mk(1, 1, 12'h030, 3, 0, 3, 0,   0, 12'h012, 5, 1, 0, 12'h012);
        vecs[7]  = mk(1, 1, 12'h030, 3, 0, 2, 0,   1, 12'h030, 3, 0, 0, 12'h012);
        vecs[8]  = mk(1, 0, 12'h030, 3, 0, 2, 0,   0, 12'h030, 3, 0, 0, 12'h012);
        vecs[9]  = mk(1, 0, 12'h030, 3, 0, 2, 0,   0, 12'h030, 3, 0, 0, 12'h012);
        vecs[10] = mk(1, 1, 12'h020, 9, 1, 0, 0,   1, 12'h020, 9, 1, 0, 12'h012);
        vecs[11] = mk(1, 1, 12'h020, 9, 1, 0, 1,   0, 12'h020, 9, 1, 1, 12'h020);
        vecs[12] = mk(1, 1, 12'h020, 9, 1, 0, 0,   0, 12'h020, 9, 1, 0, 12'h020);
        vecs[13] = mk(1, 1, 12'h020, 9, 1, 0, 0,   1, 12'h020, 9, 1, 0, 12'h020);
        vecs[14] = mk(1, 1, 12'h020, 9, 1, 0, 1,   0, 12'h020, 9, 1, 1, 12'h020);
        vecs[15] = mk(1, 0, 12'h020, 9, 1, 0, 1,   0, 12'h020, 9, 1, 0, 12'h020);
        vecs[16] = mk(1, 0, 12'h020, 9, 1, 0, 1,   0, 12'h020, 9, 1, 0, 12'h020);
        vecs[17] = mk(1, 0, 12'h020, 9, 1, 0, 1,   0, 12'h020, 9, 1, 0, 12'h020);
        vecs[18] = mk(1, 1, 12'h004, 4, 0, 0, 0,   1, 12'h004, 4, 0, 0, 12'h020);
        vecs[19] = mk(1, 1, 12'h009, 7, 1, 0, 1,   0, 12'h004, 4, 0, 1, 12'h004);
        vecs[20] = mk(1, 1, 12'h009, 7, 1, 0, 0,   0, 12'h004, 4, 0, 0, 12'h004);
        vecs[21] = mk(1, 1, 12'h009, 7, 1, 0, 0,   1, 12'h009, 7, 1, 0, 12'h004);
        vecs[22] = mk(1, 1, 12'h009, 7, 1, 0, 1,   0, 12'h009, 7, 1, 1, 12'h009);
        vecs[23] = mk(0, 0, 12'h009, 7, 1, 0, 0,   0, 12'h000, 0, 0, 0, 12'h000);
        vecs[24] = mk(1, 0, 12'h000, 0, 0, 0, 0,   0, 12'h000, 0, 0, 0, 12'h000);

        drive(0, 1, 12'h012, 5, 1, 3, 0);
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].rst_n, vecs[i].req, vecs[i].id, vecs[i].prio, vecs[i].hv,
                  vecs[i].thr, vecs[i].ack);
            if (!vecs[i].rst_n) begin
                // Reset is asynchronous: outputs, including a live clear pulse, drop without a clock edge.
                #1;
                chk("async_rst_vld", i, 32'(clic_int_vld), 32'd0);
                chk("async_rst_clr", i, 32'(pend_clr_vld), 32'd0);
            end
            @(posedge clk);
            #1;
            check_all(i, vecs[i].e_vld, vecs[i].e_id, vecs[i].e_prio, vecs[i].e_hv,
                      vecs[i].e_clr, vecs[i].e_clr_id);
        end

`ifdef CLIC_INT_PREEMPT_EN
        pre_id = 12'h009; pre_prio = 6'd7; pre_hv = 1'b1;
`else
        pre_id = 12'h004; pre_prio = 6'd4; pre_hv = 1'b0;
`endif
        // Higher-priority winner arrives while 0x004 is presented.
        @(negedge clk); drive(1, 1, 12'h004, 4, 0, 0, 0);
        @(posedge clk); #1; check_all(100, 1, 12'h004, 4, 0, 0, 12'h000);
        @(negedge clk); drive(1, 1, 12'h009, 7, 1, 0, 0);
        @(posedge clk); #1; check_all(101, 1, pre_id, pre_prio, pre_hv, 0, 12'h000);
        @(negedge clk); drive(1, 1, 12'h009, 7, 1, 0, 0);
        @(posedge clk); #1; check_all(102, 1, pre_id, pre_prio, pre_hv, 0, 12'h000);
        @(negedge clk); drive(1, 0, 12'h009, 7, 1, 0, 0);
        @(posedge clk); #1; check_all(103, 0, pre_id, pre_prio, pre_hv, 0, 12'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
